// File: rtl/lift_pkg.sv
// lift_pkg: shared types, default sizing and floor-mask helpers for the
// lift car controller slice.
//   car_state_t    IDLE / MOVING / DOOR_OPEN
//   floor_t        floor index at the default floor width
//   any_above()    any mask bit strictly above a floor
//   any_below()    any mask bit strictly below a floor
package lift_pkg;

    localparam int unsigned LIFT_NUM_FLOORS = 11;
    localparam int unsigned LIFT_FLOOR_W    = 4;

    // Helpers take a zero-extended mask so they serve any NUM_FLOORS <= MASK_W.
    localparam int unsigned MASK_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DOOR_OPEN
    } car_state_t;

    typedef logic [LIFT_FLOOR_W-1:0] floor_t;

    function automatic logic any_above(input logic [MASK_W-1:0] mask,
                                       input int unsigned       floor);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (mask[i] && (i > floor)) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [MASK_W-1:0] mask,
                                       input int unsigned       floor);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (mask[i] && (i < floor)) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lift_timer.sv
// lift_timer: loadable up-counter with terminal-count flag.
//   clk, rst   clock, asynchronous active-high reset (count -> 0)
//   load_i     synchronous clear to 0, wins over en_i
//   en_i       count up by one
//   tc_o       high while enabled and count == LIMIT-1
module lift_timer #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = $clog2(LIMIT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tc_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/lift_car_controller.sv
// lift_car_controller: per-car SCAN motion and door controller.
//   clk, rst      clock, asynchronous active-high reset
//   assign_req    dispatcher stop requests, OR-ed into pending each cycle
//   car_req       in-car floor buttons, OR-ed into pending each cycle
//   door_hold     (only with LIFT_DOOR_HOLD_EN) holds the door timer at 0
//   cur_floor     current floor (dispatcher lift state)
//   dir_up        committed direction, 1 = up
//   moving        high in MOVING
//   door_open     high in DOOR_OPEN
//   pending       outstanding stop mask
//   served_vld    one-cycle pulse per stop, with served_floor
// Optional feature macro: LIFT_DOOR_HOLD_EN.
module lift_car_controller
    import lift_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = LIFT_NUM_FLOORS,
    parameter int unsigned FLOOR_W       = LIFT_FLOOR_W,
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] assign_req,
    input  logic [NUM_FLOORS-1:0] car_req,
`ifdef LIFT_DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  served_vld,
    output logic [FLOOR_W-1:0]    served_floor
);

    car_state_t            state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d, next_floor;
    logic [FLOOR_W-1:0]    served_floor_q, served_floor_d;
    logic                  dir_q, dir_d;
    logic                  moving_q, door_q;
    logic                  served_vld_q, served_vld_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] req_in, clear_mask, here_mask, next_mask;
    logic                  here, above, below, at_limit;
    logic                  travel_tc, door_tc, travel_load, door_load;
    logic                  door_restart, hold;

`ifdef LIFT_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    assign req_in     = assign_req | car_req;
    assign here_mask  = NUM_FLOORS'(1) << floor_q;
    assign next_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    assign next_mask  = NUM_FLOORS'(1) << next_floor;
    assign here       = |(pending_q & here_mask);
    assign above      = any_above(MASK_W'(pending_q), 32'(floor_q));
    assign below      = any_below(MASK_W'(pending_q), 32'(floor_q));
    assign at_limit   = dir_q ? (floor_q == FLOOR_W'(NUM_FLOORS - 1))
                              : (floor_q == '0);

    // A fresh request for the floor whose door is open is absorbed by
    // the current stop rather than queued for a later visit.
    assign door_restart = (state_q == DOOR_OPEN) && |(req_in & here_mask);

    assign travel_load = (state_q != MOVING) || travel_tc;
    assign door_load   = (state_q != DOOR_OPEN) || door_tc || door_restart || hold;

    lift_timer #(.LIMIT(TRAVEL_CYCLES)) u_travel_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (travel_load),
        .en_i   (state_q == MOVING),
        .tc_o   (travel_tc)
    );

    lift_timer #(.LIMIT(DOOR_CYCLES)) u_door_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (door_load),
        .en_i   (state_q == DOOR_OPEN),
        .tc_o   (door_tc)
    );

    always_comb begin
        state_d        = state_q;
        floor_d        = floor_q;
        dir_d          = dir_q;
        served_vld_d   = 1'b0;
        served_floor_d = served_floor_q;
        clear_mask     = '0;

        unique case (state_q)
            IDLE: begin
                if (here) begin
                    state_d        = DOOR_OPEN;
                    clear_mask     = here_mask;
                    served_vld_d   = 1'b1;
                    served_floor_d = floor_q;
                end else if (above && (dir_q || !below)) begin
                    dir_d   = 1'b1;
                    state_d = MOVING;
                end else if (below) begin
                    dir_d   = 1'b0;
                    state_d = MOVING;
                end
            end
            MOVING: begin
                if (travel_tc) begin
                    if (at_limit) begin
                        state_d = IDLE;
                    end else begin
                        floor_d = next_floor;
                        if (|(pending_q & next_mask)) begin
                            state_d        = DOOR_OPEN;
                            clear_mask     = next_mask;
                            served_vld_d   = 1'b1;
                            served_floor_d = next_floor;
                        end
                    end
                end
            end
            DOOR_OPEN: begin
                if (door_restart) begin
                    clear_mask     = here_mask;
                    served_vld_d   = 1'b1;
                    served_floor_d = floor_q;
                end else if (door_tc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = (pending_q | req_in) & ~clear_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            floor_q        <= '0;
            dir_q          <= 1'b1;
            moving_q       <= 1'b0;
            door_q         <= 1'b0;
            served_vld_q   <= 1'b0;
            served_floor_q <= '0;
            pending_q      <= '0;
        end else begin
            state_q        <= state_d;
            floor_q        <= floor_d;
            dir_q          <= dir_d;
            moving_q       <= (state_d == MOVING);
            door_q         <= (state_d == DOOR_OPEN);
            served_vld_q   <= served_vld_d;
            served_floor_q <= served_floor_d;
            pending_q      <= pending_d;
        end
    end

    // Direction rules only commit towards a pending stop, so the car can
    // never run off either end of the shaft.
    assert property (@(posedge clk) disable iff (rst)
        !((state_q == MOVING) && travel_tc && at_limit));

    assign cur_floor    = floor_q;
    assign dir_up       = dir_q;
    assign moving       = moving_q;
    assign door_open    = door_q;
    assign pending      = pending_q;
    assign served_vld   = served_vld_q;
    assign served_floor = served_floor_q;

endmodule

// File: tb/tb_lift_car_controller.sv
// tb_lift_car_controller: directed scenarios with a served-stop scoreboard
// for lift_car_controller (TRAVEL_CYCLES=4, DOOR_CYCLES=3).
// Door-hold scenario is built only with LIFT_DOOR_HOLD_EN.
module tb_lift_car_controller;

    localparam int unsigned NF = 11;
    localparam int unsigned FW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NF-1:0] assign_req;
    logic [NF-1:0] car_req;
`ifdef LIFT_DOOR_HOLD_EN
    logic          door_hold;
`endif
    logic [FW-1:0] cur_floor;
    logic          dir_up;
    logic          moving;
    logic          door_open;
    logic [NF-1:0] pending;
    logic          served_vld;
    logic [FW-1:0] served_floor;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned sb_q[$];

    lift_car_controller #(
        .NUM_FLOORS    (NF),
        .FLOOR_W       (FW),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .assign_req   (assign_req),
        .car_req      (car_req),
`ifdef LIFT_DOOR_HOLD_EN
        .door_hold    (door_hold),
`endif
        .cur_floor    (cur_floor),
        .dir_up       (dir_up),
        .moving       (moving),
        .door_open    (door_open),
        .pending      (pending),
        .served_vld   (served_vld),
        .served_floor (served_floor)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n active edges and settle just after the last one.
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cur"},    32'(cur_floor),    32'd0);
        check({tag, "_dir"},    32'(dir_up),       32'd1);
        check({tag, "_mov"},    32'(moving),       32'd0);
        check({tag, "_door"},   32'(door_open),    32'd0);
        check({tag, "_pend"},   32'(pending),      32'd0);
        check({tag, "_svld"},   32'(served_vld),   32'd0);
        check({tag, "_sfloor"}, 32'(served_floor), 32'd0);
    endtask

    // Scoreboard: each served pulse must match the next expected floor.
    always @(negedge clk) begin : sb_mon
        int unsigned e;
        if (!rst && served_vld) begin
            check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_floor", 32'(served_floor), e);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        assign_req = '0;
        car_req    = '0;
`ifdef LIFT_DOOR_HOLD_EN
        door_hold  = 1'b0;
`endif
        #2;
        check_reset_values("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: idle at 0, dispatcher sends floor 3
        assign_req = 11'h008;
        sb_q.push_back(3);
        step(1);
        assign_req = '0;
        check("s1_pend_e0", 32'(pending), 32'h008);
        check("s1_mov_e0",  32'(moving),  32'd0);
        step(1);
        check("s1_mov_e1",  32'(moving),  32'd1);
        check("s1_cur_e1",  32'(cur_floor), 32'd0);
        step(3);
        check("s1_cur_e4",  32'(cur_floor), 32'd0);
        step(1);
        check("s1_cur_e5",  32'(cur_floor), 32'd1);
        step(4);
        check("s1_cur_e9",  32'(cur_floor), 32'd2);
        step(4);
        check("s1_cur_e13",  32'(cur_floor),    32'd3);
        check("s1_door_e13", 32'(door_open),    32'd1);
        check("s1_mov_e13",  32'(moving),       32'd0);
        check("s1_pend_e13", 32'(pending),      32'd0);
        check("s1_svld_e13", 32'(served_vld),   32'd1);
        check("s1_sfl_e13",  32'(served_floor), 32'd3);
        step(1);
        check("s1_svld_e14", 32'(served_vld),   32'd0);
        step(1);
        check("s1_door_e15", 32'(door_open),    32'd1);
        step(1);
        check("s1_door_e16", 32'(door_open),    32'd0);
        check("s1_mov_e16",  32'(moving),       32'd0);

        // back to floor 0
        #2;
        rst = 1'b1;
        #1;
        step(1);
        rst = 1'b0;

        // 2: heading to 5, in-car stop at 2 picked up on the way
        assign_req = 11'h020;
        step(1);
        assign_req = '0;
        step(1);
        car_req = 11'h004;
        sb_q.push_back(2);
        sb_q.push_back(5);
        step(1);
        car_req = '0;
        check("s2_pend_e2", 32'(pending), 32'h024);
        check("s2_mov_e2",  32'(moving),  32'd1);
        step(7);
        check("s2_cur_e9",  32'(cur_floor), 32'd2);
        check("s2_door_e9", 32'(door_open), 32'd1);
        check("s2_pend_e9", 32'(pending),   32'h020);
        check("s2_dir_e9",  32'(dir_up),    32'd1);
        step(3);
        check("s2_door_e12", 32'(door_open), 32'd0);
        check("s2_mov_e12",  32'(moving),    32'd0);
        step(1);
        check("s2_mov_e13",  32'(moving),    32'd1);
        check("s2_dir_e13",  32'(dir_up),    32'd1);
        step(12);
        check("s2_cur_e25",  32'(cur_floor), 32'd5);
        check("s2_door_e25", 32'(door_open), 32'd1);
        check("s2_pend_e25", 32'(pending),   32'd0);
        step(3);
        check("s2_door_e28", 32'(door_open), 32'd0);

        // 3a: down one floor to 4
        assign_req = 11'h010;
        sb_q.push_back(4);
        step(1);
        assign_req = '0;
        step(1);
        check("s3_dir_down", 32'(dir_up), 32'd0);
        step(4);
        check("s3_cur_4",    32'(cur_floor), 32'd4);
        check("s3_door_4",   32'(door_open), 32'd1);
        step(3);
        check("s3_idle_4",   32'(moving | door_open), 32'd0);

        // 3b: 4 -> 8 with a request behind at 1 arriving mid-trip
        assign_req = 11'h100;
        sb_q.push_back(8);
        step(1);
        assign_req = '0;
        step(1);
        check("s3_dir_up",   32'(dir_up), 32'd1);
        check("s3_mov_up",   32'(moving), 32'd1);
        step(1);
        assign_req = 11'h002;
        sb_q.push_back(1);
        step(1);
        assign_req = '0;
        check("s3_pend_both", 32'(pending), 32'h102);
        step(14);
        check("s3_cur_8",     32'(cur_floor), 32'd8);
        check("s3_door_8",    32'(door_open), 32'd1);
        check("s3_pend_8",    32'(pending),   32'h002);
        step(3);
        check("s3_idle_8",    32'(moving | door_open), 32'd0);
        check("s3_dir_hold",  32'(dir_up), 32'd1);
        step(1);
        check("s3_rev_dir",   32'(dir_up), 32'd0);
        check("s3_rev_mov",   32'(moving), 32'd1);
        step(28);
        check("s3_cur_1",     32'(cur_floor), 32'd1);
        check("s3_door_1",    32'(door_open), 32'd1);
        check("s3_pend_1",    32'(pending),   32'd0);
        step(3);

        // 4: door open at 6, button 6 pressed again
        assign_req = 11'h040;
        sb_q.push_back(6);
        step(1);
        assign_req = '0;
        step(21);
        check("s4_cur_6",   32'(cur_floor), 32'd6);
        check("s4_door_6",  32'(door_open), 32'd1);
        car_req = 11'h040;
        sb_q.push_back(6);
        step(1);
        car_req = '0;
        check("s4_pend_clr", 32'(pending),      32'd0);
        check("s4_svld",     32'(served_vld),   32'd1);
        check("s4_sfloor",   32'(served_floor), 32'd6);
        step(2);
        check("s4_door_ext", 32'(door_open), 32'd1);
        step(1);
        check("s4_door_cls", 32'(door_open), 32'd0);

        // 5: reset mid-travel between 2 and 3 with pending 0x0F0
        #2;
        rst = 1'b1;
        #1;
        step(1);
        rst = 1'b0;
        assign_req = 11'h0F0;
        step(1);
        assign_req = '0;
        step(10);
        check("s5_cur_pre",  32'(cur_floor), 32'd2);
        check("s5_mov_pre",  32'(moving),    32'd1);
        check("s5_pend_pre", 32'(pending),   32'h0F0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("s5_async");
        step(1);
        rst = 1'b0;
        step(10);
        check("s5_cur_post",  32'(cur_floor), 32'd0);
        check("s5_mov_post",  32'(moving),    32'd0);
        check("s5_pend_post", 32'(pending),   32'd0);

`ifdef LIFT_DOOR_HOLD_EN
        // 6: door held open at floor 0
        car_req   = 11'h001;
        door_hold = 1'b1;
        sb_q.push_back(0);
        step(1);
        car_req = '0;
        step(1);
        check("s6_door_e1",  32'(door_open), 32'd1);
        step(19);
        check("s6_door_e20", 32'(door_open), 32'd1);
        door_hold = 1'b0;
        step(2);
        check("s6_door_e22", 32'(door_open), 32'd1);
        step(1);
        check("s6_door_e23", 32'(door_open), 32'd0);
`endif

        step(2);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
